// File: rtl/sigma_decim.sv
// Third-order CIC (sinc^3) decimator for a 1-bit sigma-delta stream.
// Output is unsigned, saturated and left-justified in a 32-bit word.
module sigma_decim #(
    parameter int unsigned LOG2R = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_in,
    input  logic        bit_en,
    output logic [31:0] pcm,
    output logic        out_valid,
    output logic        out_settled
);

    localparam int unsigned W  = 3 * LOG2R + 1;
    localparam int unsigned CW = 3 * LOG2R;

    logic [W-1:0]     int1_q, int2_q, int3_q;
    logic [W-1:0]     int1_d, int2_d, int3_d;
    logic [W-1:0]     snap_q;
    logic [W-1:0]     dly1_q, dly2_q, dly3_q;
    logic [W-1:0]     comb1_d, comb2_d, comb3_d;
    logic [CW-1:0]    sat_d;
    logic [31:0]      pcm_q, pcm_d;
    logic [LOG2R-1:0] cnt_q;
    logic             dec_q;
    logic             valid_q;
    logic [1:0]       settle_q;

    // Integrators chain combinationally so the snapshot includes the bit consumed on the same edge.
    always_comb begin
        int1_d  = int1_q + W'(bit_in);
        int2_d  = int2_q + int1_d;
        int3_d  = int3_q + int2_d;
        comb1_d = snap_q - dly1_q;
        comb2_d = comb1_d - dly2_q;
        comb3_d = comb2_d - dly3_q;
        sat_d   = comb3_d[W-1] ? '1 : comb3_d[CW-1:0];
        pcm_d   = {sat_d, {(32 - CW){1'b0}}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int1_q   <= '0;
            int2_q   <= '0;
            int3_q   <= '0;
            snap_q   <= '0;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
        end else begin
            dec_q <= bit_en && (cnt_q == '1);
            if (bit_en) begin
                int1_q <= int1_d;
                int2_q <= int2_d;
                int3_q <= int3_d;
                cnt_q  <= cnt_q + LOG2R'(1);
                if (cnt_q == '1) begin
                    snap_q <= int3_d;
                end
            end
        end
    end

    // Comb stage runs one edge after the snapshot, isolated from further integrator updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly1_q   <= '0;
            dly2_q   <= '0;
            dly3_q   <= '0;
            pcm_q    <= '0;
            valid_q  <= 1'b0;
            settle_q <= '0;
        end else begin
            valid_q <= dec_q;
            if (dec_q) begin
                dly1_q <= snap_q;
                dly2_q <= comb1_d;
                dly3_q <= comb2_d;
                pcm_q  <= pcm_d;
                if (settle_q != 2'd3) begin
                    settle_q <= settle_q + 2'd1;
                end
            end
        end
    end

    assign pcm         = pcm_q;
    assign out_valid   = valid_q;
    assign out_settled = (settle_q == 2'd3);

endmodule

// File: tb/tb_sigma_decim.sv
// Directed bench for sigma_decim: expected samples come from a direct sinc^3
// convolution over the consumed-bit history and are queued until out_valid.
module tb_sigma_decim;

    localparam int LOG2R = 6;
    localparam int R     = 64;
    localparam int KL    = 3 * (R - 1) + 1;
    localparam int CW    = 3 * LOG2R;

    logic        clk;
    logic        rst;
    logic        bit_in;
    logic        bit_en;
    logic [31:0] pcm;
    logic        out_valid;
    logic        out_settled;

    sigma_decim #(.LOG2R(LOG2R)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_en      (bit_en),
        .pcm         (pcm),
        .out_valid   (out_valid),
        .out_settled (out_settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    longint      h [KL];
    logic [KL-1:0] hist;
    int          consumed;
    int          cyc;
    int          due;
    int          pulses;
    logic [31:0] last_pcm;
    logic [31:0] exp_q [$];
    longint      sd_acc;

    function automatic logic [31:0] model_pcm(input logic [KL-1:0] hv);
        longint      acc;
        logic [31:0] v;
        acc = 0;
        for (int j = 0; j < KL; j++) begin
            if (hv[j]) acc += h[j];
        end
        if (acc > (longint'(1) << CW) - 1) acc = (longint'(1) << CW) - 1;
        v = 32'(acc);
        return v << (32 - CW);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic b);
        bit_en = en;
        bit_in = b;
        if (en) begin
            hist = {hist[KL-2:0], b};
            consumed++;
            if (consumed % R == 0) begin
                exp_q.push_back(model_pcm(hist));
                due = cyc + 2;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check("out_valid", 32'(out_valid), 32'(cyc == due));
        if (out_valid && exp_q.size() > 0) begin
            last_pcm = exp_q.pop_front();
            pulses++;
        end
        check("pcm", pcm, last_pcm);
        check("out_settled", 32'(out_settled), 32'(pulses >= 3));
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        bit_en = 1'b0;
        bit_in = 1'b0;
        #1;
        check("rst_pcm", pcm, 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_settled", 32'(out_settled), 32'h0);
        hist     = '0;
        consumed = 0;
        pulses   = 0;
        last_pcm = '0;
        due      = -1;
        exp_q.delete();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        due      = -1;
        hist     = '0;
        consumed = 0;
        pulses   = 0;
        last_pcm = '0;
        rst      = 1'b0;
        bit_en   = 1'b0;
        bit_in   = 1'b0;
        for (int j = 0; j < KL; j++) h[j] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a + b + c] += 1;

        // All ones: saturated full scale from the third sample on.
        do_reset();
        for (int i = 0; i < 3 * R; i++) step(1'b1, 1'b1);
        drain(2);
        check("ones_3rd_pcm", pcm, 32'hFFFFC000);
        check("ones_3rd_settled", 32'(out_settled), 32'h1);
        for (int i = 0; i < 3 * R; i++) step(1'b1, 1'b1);
        drain(2);
        check("ones_late_pcm", pcm, 32'hFFFFC000);

        // All zeros.
        do_reset();
        for (int i = 0; i < 5 * R; i++) step(1'b1, 1'b0);
        drain(2);
        check("zeros_pcm", pcm, 32'h0);
        check("zeros_settled", 32'(out_settled), 32'h1);

        // Alternating 1,0 settles at mid scale.
        do_reset();
        for (int i = 0; i < 5 * R; i++) step(1'b1, 1'(~i[0]));
        drain(2);
        check("alt_pcm", pcm, 32'h80000000);

        // Reset while cnt = 40 discards the partial frame.
        do_reset();
        for (int i = 0; i < 3 * R + 40; i++) step(1'b1, 1'b1);
        check("pre_rst_settled", 32'(out_settled), 32'h1);
        do_reset();
        for (int i = 0; i < 3 * R; i++) step(1'b1, 1'b1);
        drain(2);
        check("post_rst_pcm", pcm, 32'hFFFFC000);

        // Sparse bit_en at ~30% duty: spacing counts consumed bits only.
        do_reset();
        for (int it = 0; it < 4000 && consumed < 4 * R; it++)
            step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, 1'b1);
        check("rand_consumed", 32'(consumed), 32'(4 * R));
        drain(3);
        check("rand_pcm", pcm, 32'hFFFFC000);

        // First-order sigma-delta modulator, tiny input then quarter scale.
        do_reset();
        sd_acc = 0;
        for (int i = 0; i < 6 * R; i++) begin
            sd_acc += 3;
            step(1'b1, (sd_acc >= (longint'(1) << 32)) ? 1'b1 : 1'b0);
            if (sd_acc >= (longint'(1) << 32)) sd_acc -= (longint'(1) << 32);
        end
        drain(2);
        check("sd_small", 32'(pcm <= 32'h4000), 32'h1);
        for (int i = 0; i < 8 * R; i++) begin
            sd_acc += 64'h40000000;
            step(1'b1, (sd_acc >= (longint'(1) << 32)) ? 1'b1 : 1'b0);
            if (sd_acc >= (longint'(1) << 32)) sd_acc -= (longint'(1) << 32);
        end
        drain(2);
        check("sd_quarter", pcm, 32'h40000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
